// File: rtl/mode_ctrl_pkg.sv
// Shared definitions for the clock's front-panel path: mode encodings, button
// width and mode-button index, used by the button mux and the time/alarm blocks.
package mode_ctrl_pkg;

    localparam int BTN_W        = 5;
    localparam int MODE_BIT_DEF = 4;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_ALARM = 2'b01,
        MODE_TIME  = 2'b10
    } mode_e;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:   next_mode = MODE_ALARM;
            MODE_ALARM: next_mode = MODE_TIME;
            default:    next_mode = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/mode_ctrl_btn_debounce.sv
// One button bit: two-flop synchroniser, stable-count debounce and
// rising-edge press detect on the accepted level.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CW      = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The >= compare doubles as saturation: the counter can never pass CNT_MAX.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q >= CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;
    assign press = stable_q & ~prev_q;

endmodule

// File: rtl/mode_ctrl.sv
// Button conditioning plus RUN/ALARM_SET/TIME_SET mode sequencer; drives the
// button-mux select and press pulses registered together so they stay aligned.
module mode_ctrl
    import mode_ctrl_pkg::*;
#(
    parameter int          DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned TIMEOUT_CYC  = 1_500_000_000,
    parameter int          MODE_BIT     = MODE_BIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BTN_W-1:0] button_bus,
    output logic [1:0]       sel,
    output logic [BTN_W-1:0] btn_pulse,
    output logic [BTN_W-1:0] btn_level,
    output logic             timeout_evt
);

    localparam int             TW        = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0]  TCNT_MAX  = TW'(TIMEOUT_CYC - 1);
    localparam logic [BTN_W-1:0] MODE_MASK = BTN_W'(1) << MODE_BIT;

    logic [BTN_W-1:0] press;
    logic [BTN_W-1:0] other_press;
    logic             mode_press;

    mode_e            state_q, state_d;
    logic [BTN_W-1:0] pulse_q, pulse_d;
    logic             evt_q, evt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;

    generate
        for (genvar gi = 0; gi < BTN_W; gi++) begin : g_db
            btn_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_db (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (button_bus[gi]),
                .level(btn_level[gi]),
                .press(press[gi])
            );
        end
    endgenerate

    assign mode_press  = press[MODE_BIT];
    assign other_press = press & ~MODE_MASK;

    // Timeout outranks every press; a mode press outranks (and drops) the others.
    always_comb begin
        state_d = state_q;
        pulse_d = other_press;
        evt_d   = 1'b0;
        tcnt_d  = '0;
        if (state_q != MODE_RUN && tcnt_q >= TCNT_MAX) begin
            state_d = MODE_RUN;
            evt_d   = 1'b1;
            pulse_d = '0;
        end else begin
            if (state_q != MODE_RUN && press == '0) begin
                tcnt_d = tcnt_q + TW'(1);
            end
            if (mode_press) begin
                state_d = next_mode(state_q);
                pulse_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MODE_RUN;
            pulse_q <= '0;
            evt_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            evt_q   <= evt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign sel         = state_q;
    assign btn_pulse   = pulse_q;
    assign timeout_evt = evt_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Scoreboard bench for mode_ctrl with short debounce/timeout constants.
module tb_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] button_bus;
    logic [1:0] sel;
    logic [4:0] btn_pulse;
    logic [4:0] btn_level;
    logic       timeout_evt;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
        logic [4:0] pulse;
        logic       evt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [1:0] prev_sel = 2'b00;

    mode_ctrl #(
        .DEBOUNCE_CYC(4),
        .TIMEOUT_CYC (20),
        .MODE_BIT    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button_bus (button_bus),
        .sel        (sel),
        .btn_pulse  (btn_pulse),
        .btn_level  (btn_level),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int at, input logic [1:0] s, input logic [4:0] p, input logic e);
        exp_t x;
        x.cyc = at; x.sel = s; x.pulse = p; x.evt = e;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, req);
    endtask

    // Monitor: any pulse, timeout event or select change is one DUT transaction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_sel = sel;
        end else begin
            if (btn_pulse != 5'b0 || timeout_evt || sel != prev_sel) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_event: cyc=%0d sel=%b pulse=%b evt=%b, expected no event",
                             cyc, sel, btn_pulse, timeout_evt);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc == cyc && e.sel === sel && e.pulse === btn_pulse && e.evt === timeout_evt) begin
                        n_pass++;
                        $display("event ok: cyc=%0d sel=%b pulse=%b evt=%b", cyc, sel, btn_pulse, timeout_evt);
                    end else begin
                        $display("FAIL event: got cyc=%0d sel=%b pulse=%b evt=%b, expected cyc=%0d sel=%b pulse=%b evt=%b",
                                 cyc, sel, btn_pulse, timeout_evt, e.cyc, e.sel, e.pulse, e.evt);
                    end
                end
            end
            prev_sel = sel;
        end
    end

    initial begin
        int c;
        exp_t left;
        rst_n      = 1'b0;
        button_bus = 5'b0;
        tick(3);
        check("reset_sel",   {6'b0, sel},         8'd0);
        check("reset_pulse", {3'b0, btn_pulse},   8'd0);
        check("reset_level", {3'b0, btn_level},   8'd0);
        check("reset_evt",   {7'b0, timeout_evt}, 8'd0);
        rst_n = 1'b1;
        tick(3);

        // Clean mode press, then idle until the ALARM_SET timeout.
        c = cyc;
        button_bus[4] = 1'b1;
        push(c + 7,  2'b01, 5'b00000, 1'b0);
        push(c + 27, 2'b00, 5'b00000, 1'b1);
        tick(10);
        button_bus[4] = 1'b0;
        tick(20);

        // Three-cycle glitch rejected; six-cycle press accepted.
        button_bus[0] = 1'b1;
        tick(3);
        button_bus[0] = 1'b0;
        tick(10);
        check("glitch_level", {3'b0, btn_level}, 8'd0);
        c = cyc;
        button_bus[0] = 1'b1;
        push(c + 7, 2'b00, 5'b00001, 1'b0);
        tick(6);
        button_bus[0] = 1'b0;
        tick(3);
        check("held_level", {3'b0, btn_level}, 8'b0000_0001);
        tick(10);

        // Full mode cycle, presses 15 clk apart.
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            button_bus[4] = 1'b1;
            push(c + 15 * k + 7, (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : 2'b00, 5'b0, 1'b0);
            tick(5);
            button_bus[4] = 1'b0;
            tick(10);
        end
        tick(5);

        // A bit2 press 15 clk into ALARM_SET defers the timeout.
        c = cyc;
        button_bus[4] = 1'b1;
        push(c + 7, 2'b01, 5'b00000, 1'b0);
        tick(5);
        button_bus[4] = 1'b0;
        tick(10);
        button_bus[2] = 1'b1;
        push(c + 22, 2'b01, 5'b00100, 1'b0);
        push(c + 42, 2'b00, 5'b00000, 1'b1);
        tick(5);
        button_bus[2] = 1'b0;
        tick(25);

        // Simultaneous presses: mode wins; two non-mode presses pass together.
        c = cyc;
        button_bus = 5'b10010;
        push(c + 7, 2'b01, 5'b00000, 1'b0);
        tick(5);
        button_bus = 5'b0;
        tick(10);
        button_bus = 5'b00110;
        push(c + 22, 2'b01, 5'b00110, 1'b0);
        tick(5);
        button_bus = 5'b0;
        tick(10);
        button_bus[4] = 1'b1;
        push(c + 37, 2'b10, 5'b00000, 1'b0);
        tick(5);
        button_bus[4] = 1'b0;
        tick(10);

        // Async reset mid-debounce in TIME_SET, button held through it.
        button_bus[0] = 1'b1;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sel",   {6'b0, sel},         8'd0);
        check("async_pulse", {3'b0, btn_pulse},   8'd0);
        check("async_level", {3'b0, btn_level},   8'd0);
        check("async_evt",   {7'b0, timeout_evt}, 8'd0);
        tick(3);
        rst_n = 1'b1;
        c = cyc;
        push(c + 7, 2'b00, 5'b00001, 1'b0);
        tick(12);
        button_bus[0] = 1'b0;
        tick(12);

        while (sb.size() != 0) begin
            left = sb.pop_front();
            n_total++;
            $display("FAIL missing_event: got none, expected cyc=%0d sel=%b pulse=%b evt=%b",
                     left.cyc, left.sel, left.pulse, left.evt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
